// File: rtl/stage_sequencer_n_pkg.sv
// Shared definitions for the multicycle stage sequencer: FSM state encoding and
// default stage indices of the classic five-stage instruction cycle.
package stage_sequencer_n_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StActive  = 2'd1,
    StWaitMfc = 2'd2,
    StHalted  = 2'd3
  } seq_state_e;

  localparam int unsigned STG_FETCH     = 0;
  localparam int unsigned STG_DECODE    = 1;
  localparam int unsigned STG_EXECUTE   = 2;
  localparam int unsigned STG_MEMORY    = 3;
  localparam int unsigned STG_WRITEBACK = 4;

endpackage

// File: rtl/stage_sequencer_n_mfc_wait_timer.sv
// Wait-for-MFC cycle counter. Loads 1 on entry to the wait state, counts each
// cycle MFC is still low, and flags expiry once MFC_TIMEOUT cycles have elapsed.
module stage_sequencer_n_mfc_wait_timer #(
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic i_clock,
  input  logic i_reset_l,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_wait,
  output logic o_timeout
);

  logic [7:0] r_count;
  logic [7:0] w_count_d;
  logic       w_expired;

  assign w_expired = (r_count >= 8'(MFC_TIMEOUT));
  assign o_timeout = w_expired;

  always_comb begin
    w_count_d = r_count;
    if (i_clear) begin
      w_count_d = '0;
    end else if (i_load) begin
      w_count_d = 8'd1;
    end else if (i_wait && !w_expired) begin
      w_count_d = r_count + 8'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

endmodule

// File: rtl/stage_sequencer_n.sv
// Multicycle stage sequencer with MFC handshake, stall, boundary halt and retire count.
// Optional STAGE_SKIP_EN: non-memory instructions skip MEM_STAGE entirely.
module stage_sequencer_n
  import stage_sequencer_n_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned STAGE_W     = 4,
  parameter int unsigned FETCH_STAGE = STG_FETCH,
  parameter int unsigned MEM_STAGE   = STG_MEMORY,
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_l,
  input  logic                  i_start,
  input  logic                  i_halt_req,
  input  logic                  i_stall,
  input  logic                  i_mem_access,
  input  logic                  i_mfc,
  output logic [STAGE_W-1:0]    o_stage,
  output logic [NUM_STAGES-1:0] o_stage_onehot,
  output logic                  o_mem_req,
  output logic                  o_instr_done,
  output logic [CNT_W-1:0]      o_instr_count,
  output logic                  o_timeout_err,
  output logic                  o_busy
);

  seq_state_e              r_state, w_state_d;
  logic [STAGE_W-1:0]      r_stage, w_stage_d, w_stage_inc;
  logic [NUM_STAGES-1:0]   r_onehot, w_onehot_d;
  logic                    r_instr_done, w_instr_done_d;
  logic [CNT_W-1:0]        r_count, w_count_d;
  logic                    r_timeout_err, w_timeout_err_d;
  logic                    w_running, w_is_mem_stage, w_last, w_can_adv, w_advance;
  logic                    w_t_clear, w_t_load, w_t_wait, w_t_expired;

  assign w_running      = (r_state == StActive) || (r_state == StWaitMfc);
  assign w_is_mem_stage = (r_stage == STAGE_W'(FETCH_STAGE)) ||
                          ((r_stage == STAGE_W'(MEM_STAGE)) && i_mem_access);
  assign w_last         = (r_stage == STAGE_W'(NUM_STAGES - 1));
  assign w_can_adv      = !i_stall && (!w_is_mem_stage || i_mfc);

`ifdef STAGE_SKIP_EN
  localparam bit SkipOk = (MEM_STAGE >= 1) && (MEM_STAGE + 1 < NUM_STAGES);
`endif

  always_comb begin
    w_stage_inc = r_stage + 1'b1;
    if (w_last) begin
      w_stage_inc = '0;
    end
`ifdef STAGE_SKIP_EN
    else if (SkipOk && (r_stage == STAGE_W'(MEM_STAGE - 1)) && !i_mem_access) begin
      w_stage_inc = STAGE_W'(MEM_STAGE + 1);
    end
`endif
  end

  always_comb begin
    w_state_d       = r_state;
    w_stage_d       = r_stage;
    w_instr_done_d  = 1'b0;
    w_count_d       = r_count;
    w_timeout_err_d = r_timeout_err;
    w_t_clear       = 1'b0;
    w_t_load        = 1'b0;
    w_t_wait        = 1'b0;
    w_advance       = 1'b0;

    unique case (r_state)
      StIdle, StHalted: begin
        if (i_start) begin
          w_state_d       = StActive;
          w_stage_d       = '0;
          w_timeout_err_d = 1'b0;
          w_t_clear       = 1'b1;
        end
      end
      StActive: begin
        if (w_can_adv) begin
          w_advance = 1'b1;
        end else if (w_is_mem_stage && !i_mfc) begin
          w_state_d = StWaitMfc;
          w_t_load  = 1'b1;
        end
      end
      StWaitMfc: begin
        if (i_mfc) begin
          if (!i_stall) begin
            w_advance = 1'b1;
            w_state_d = StActive;
            w_t_clear = 1'b1;
          end
        end else begin
          w_t_wait = 1'b1;
          // Stage is left untouched so the faulting index stays visible.
          if (w_t_expired) begin
            w_state_d       = StHalted;
            w_timeout_err_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_advance) begin
      w_stage_d = w_stage_inc;
      if (w_last) begin
        w_instr_done_d = 1'b1;
        w_count_d      = r_count + 1'b1;
        if (i_halt_req) begin
          w_state_d = StHalted;
        end
      end
    end

    w_onehot_d = '0;
    if ((w_state_d == StActive) || (w_state_d == StWaitMfc)) begin
      w_onehot_d = NUM_STAGES'(1) << w_stage_d;
    end
  end

  stage_sequencer_n_mfc_wait_timer #(
    .MFC_TIMEOUT (MFC_TIMEOUT)
  ) u_mfc_wait_timer (
    .i_clock   (i_clock),
    .i_reset_l (i_reset_l),
    .i_clear   (w_t_clear),
    .i_load    (w_t_load),
    .i_wait    (w_t_wait),
    .o_timeout (w_t_expired)
  );

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state       <= StIdle;
      r_stage       <= '0;
      r_onehot      <= '0;
      r_instr_done  <= 1'b0;
      r_count       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_stage       <= w_stage_d;
      r_onehot      <= w_onehot_d;
      r_instr_done  <= w_instr_done_d;
      r_count       <= w_count_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  assign o_stage        = r_stage;
  assign o_stage_onehot = r_onehot;
  assign o_mem_req      = w_running && w_is_mem_stage;
  assign o_instr_done   = r_instr_done;
  assign o_instr_count  = r_count;
  assign o_timeout_err  = r_timeout_err;
  assign o_busy         = w_running;

endmodule

// File: tb/tb_stage_sequencer_n.sv
// Scenario bench for stage_sequencer_n; retire counts are checked through a scoreboard queue.
// Build with STAGE_SKIP_EN defined to exercise the stage-skip tables.
module tb_stage_sequencer_n;

  localparam int unsigned NS = 5;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 15;

  logic          i_clock, i_reset_l, i_start, i_halt_req, i_stall, i_mem_access, i_mfc;
  logic [SW-1:0] o_stage;
  logic [NS-1:0] o_stage_onehot;
  logic          o_mem_req, o_instr_done, o_timeout_err, o_busy;
  logic [CW-1:0] o_instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] sb[$];

  stage_sequencer_n #(
    .NUM_STAGES  (NS),
    .STAGE_W     (SW),
    .FETCH_STAGE (0),
    .MEM_STAGE   (3),
    .MFC_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .i_clock        (i_clock),
    .i_reset_l      (i_reset_l),
    .i_start        (i_start),
    .i_halt_req     (i_halt_req),
    .i_stall        (i_stall),
    .i_mem_access   (i_mem_access),
    .i_mfc          (i_mfc),
    .o_stage        (o_stage),
    .o_stage_onehot (o_stage_onehot),
    .o_mem_req      (o_mem_req),
    .o_instr_done   (o_instr_done),
    .o_instr_count  (o_instr_count),
    .o_timeout_err  (o_timeout_err),
    .o_busy         (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset;
    i_reset_l = 1'b0; i_start = 1'b0; i_halt_req = 1'b0; i_stall = 1'b0;
    i_mem_access = 1'b0; i_mfc = 1'b0;
    sb.delete();
    repeat (2) tick();
    i_reset_l = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [SW+NS+CW+4-1:0] obs;
    do_reset();
    obs = {o_stage, o_stage_onehot, o_mem_req, o_instr_done, o_instr_count, o_timeout_err, o_busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({o_busy, o_mem_req, o_stage} !== {1'b1, 1'b1, SW'(0)}) begin
      n_fail++;
      $display("FAIL wait_before_reset busy/mreq/stage got %b/%b/%0d want 1/1/0",
               o_busy, o_mem_req, o_stage);
    end
    #2 i_reset_l = 1'b0;
    #1;
    obs = {o_stage, o_stage_onehot, o_mem_req, o_instr_done, o_instr_count, o_timeout_err, o_busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset_mid_wait got %h want 0", obs);
    end
    tick();
    i_reset_l = 1'b1;
    repeat (2) tick();
    obs = {o_stage, o_stage_onehot, o_mem_req, o_instr_done, o_instr_count, o_timeout_err, o_busy};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %h want 0", obs);
    end
  endtask

  task automatic test_sequence(input bit mem_acc);
    int unsigned   seq[$];
    int unsigned   len, exp_stage;
    logic [CW-1:0] exp_cnt, popped;
    logic [NS-1:0] exp_oh;
    bit            exp_done, exp_mreq;
`ifdef STAGE_SKIP_EN
    if (!mem_acc) seq = {0, 1, 2, 4};
    else          seq = {0, 1, 2, 3, 4};
`else
    seq = {0, 1, 2, 3, 4};
`endif
    do_reset();
    i_mfc = 1'b1;
    i_mem_access = mem_acc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    len = seq.size();
    exp_cnt = '0;
    for (int k = 0; k <= 3 * int'(len); k++) begin
      exp_stage = seq[k % len];
      exp_done  = (k > 0) && (k % len == 0);
      exp_mreq  = (exp_stage == 0) || ((exp_stage == 3) && mem_acc);
      exp_oh    = NS'(1) << exp_stage;
      n_checks++;
      if ({o_stage, o_stage_onehot} !== {SW'(exp_stage), exp_oh}) begin
        n_fail++;
        $display("FAIL seq%0d_stage k=%0d got %0d/%b want %0d/%b", mem_acc, k, o_stage,
                 o_stage_onehot, exp_stage, exp_oh);
      end
      n_checks++;
      if ({o_mem_req, o_instr_done} !== {exp_mreq, exp_done}) begin
        n_fail++;
        $display("FAIL seq%0d_mreq_done k=%0d got %b%b want %b%b", mem_acc, k, o_mem_req,
                 o_instr_done, exp_mreq, exp_done);
      end
      if (o_instr_done === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL seq%0d_sb_unexpected_done k=%0d got done want none", mem_acc, k);
        end else begin
          popped = sb.pop_front();
          if (o_instr_count !== popped) begin
            n_fail++;
            $display("FAIL seq%0d_count k=%0d got %0d want %0d", mem_acc, k, o_instr_count,
                     popped);
          end
        end
      end
      if (k % len == len - 1) begin
        exp_cnt++;
        sb.push_back(exp_cnt);
      end
      if (k < 3 * int'(len)) tick();
    end
    n_checks++;
    if (sb.size() != 0 || o_instr_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL seq%0d_final got count %0d pending %0d want 3/0", mem_acc, o_instr_count,
               sb.size());
    end
  endtask

  task automatic test_mfc_delay;
    int unsigned   tbl[$];
    int unsigned   last;
    logic [CW-1:0] popped;
`ifdef STAGE_SKIP_EN
    tbl = {0, 0, 0, 0, 0, 1, 2, 4, 0};
`else
    tbl = {0, 0, 0, 0, 0, 1, 2, 3, 4, 0};
`endif
    last = tbl.size() - 1;
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k <= int'(last); k++) begin
      n_checks++;
      if ({o_stage, o_mem_req, o_busy} !== {SW'(tbl[k]), (tbl[k] == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL mfc_delay_stage k=%0d got %0d/%b/%b want %0d/%b/1", k, o_stage,
                 o_mem_req, o_busy, tbl[k], (tbl[k] == 0));
      end
      n_checks++;
      if (o_instr_done !== (k == int'(last))) begin
        n_fail++;
        $display("FAIL mfc_delay_done k=%0d got %b want %b", k, o_instr_done, (k == int'(last)));
      end
      if (o_instr_done === 1'b1) begin
        n_checks++;
        popped = (sb.size() != 0) ? sb.pop_front() : '1;
        if (o_instr_count !== popped) begin
          n_fail++;
          $display("FAIL mfc_delay_count got %0d want %0d", o_instr_count, popped);
        end
      end
      if (k == int'(last) - 1) sb.push_back(CW'(1));
      i_mfc = (k >= 4);
      if (k < int'(last)) tick();
    end
  endtask

  task automatic test_timeout;
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 15) begin
        n_checks++;
        if ({o_busy, o_timeout_err, o_mem_req, o_stage} !== {1'b1, 1'b0, 1'b1, SW'(0)}) begin
          n_fail++;
          $display("FAIL timeout_waiting k=%0d got busy%b err%b mreq%b stage%0d want 1 0 1 0",
                   k, o_busy, o_timeout_err, o_mem_req, o_stage);
        end
      end else begin
        n_checks++;
        if ({o_busy, o_timeout_err, o_mem_req, o_stage, o_stage_onehot} !==
            {1'b0, 1'b1, 1'b0, SW'(0), NS'(0)}) begin
          n_fail++;
          $display("FAIL timeout_halted got busy%b err%b mreq%b stage%0d oh%b want 0 1 0 0 0",
                   o_busy, o_timeout_err, o_mem_req, o_stage, o_stage_onehot);
        end
      end
    end
    repeat (3) tick();
    n_checks++;
    if ({o_busy, o_timeout_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_sticky got busy%b err%b want 0 1", o_busy, o_timeout_err);
    end
    i_start = 1'b1;
    i_mfc = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++;
    if ({o_busy, o_timeout_err, o_stage} !== {1'b1, 1'b0, SW'(0)}) begin
      n_fail++;
      $display("FAIL timeout_restart got busy%b err%b stage%0d want 1 0 0", o_busy,
               o_timeout_err, o_stage);
    end
  endtask

  task automatic test_stall_halt;
    int unsigned   tbl[$];
    int unsigned   last;
    logic [CW-1:0] popped;
`ifdef STAGE_SKIP_EN
    tbl = {0, 1, 2, 2, 2, 2, 4, 0};
`else
    tbl = {0, 1, 2, 2, 2, 2, 3, 4, 0};
`endif
    last = tbl.size() - 1;
    do_reset();
    i_mfc = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k <= int'(last); k++) begin
      n_checks++;
      if ({o_stage, o_busy, o_instr_done} !==
          {SW'(tbl[k]), (k != int'(last)), (k == int'(last))}) begin
        n_fail++;
        $display("FAIL stall_halt k=%0d got stage%0d busy%b done%b want %0d %b %b", k, o_stage,
                 o_busy, o_instr_done, tbl[k], (k != int'(last)), (k == int'(last)));
      end
      if (o_instr_done === 1'b1) begin
        n_checks++;
        popped = (sb.size() != 0) ? sb.pop_front() : '1;
        if (o_instr_count !== popped) begin
          n_fail++;
          $display("FAIL stall_halt_count got %0d want %0d", o_instr_count, popped);
        end
      end
      if (k == int'(last) - 1) sb.push_back(CW'(1));
      i_stall = (k >= 2) && (k <= 4);
      if (k == 6) i_halt_req = 1'b1;
      if (k < int'(last)) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({o_instr_done, o_busy, o_stage_onehot, o_instr_count} !== {1'b0, 1'b0, NS'(0), CW'(1)})
      begin
        n_fail++;
        $display("FAIL stall_halt_stays k=%0d got done%b busy%b oh%b cnt%0d want 0 0 0 1", k,
                 o_instr_done, o_busy, o_stage_onehot, o_instr_count);
      end
    end
    i_halt_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_mfc_delay();
    test_timeout();
    test_stall_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
